// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI slave front end: FSM state encoding and default sizes.
// Optional feature macro SPI_TX_UNDERRUN_EN is consumed by spi_slave_if.
package spi_slave_if_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int SPI_DEFAULT_WIDTH = 8;
    localparam int SPI_MIN_SYNC      = 2;

endpackage

// File: rtl/spi_slave_if_sync.sv
// spi_sync: multi-flop synchroniser for one asynchronous pin, resetting to the pin's idle level.
module spi_sync
    import spi_slave_if_pkg::*;
#(
    parameter int   STAGES  = SPI_MIN_SYNC,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: synchronises pins, assembles rx words, serialises tx words onto miso.
// Define SPI_TX_UNDERRUN_EN to add the sticky tx_underrun output.
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = SPI_MIN_SYNC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_rdy,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
`ifdef SPI_TX_UNDERRUN_EN
    output logic                  tx_underrun,
`endif
    output logic                  busy
);

    localparam int              CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

    logic sck_s, cs_n_s, mosi_s;
    logic sck_d, sck_dd, cs_n_d, mosi_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .din(sck),  .dout(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .din(cs_n), .dout(cs_n_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .din(mosi), .dout(mosi_s));

    state_t                  state;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   tx_hold;
    logic [DATA_WIDTH-1:0]   rx_word;
    logic                    sck_rise, sck_fall;
    logic                    frame_start, word_done, shift_load;

    // All pin-derived strobes come from one aligned delayed stage, so mosi and cs_n line up with the sck edges.
    assign sck_rise    = sck_d & ~sck_dd;
    assign sck_fall    = ~sck_d & sck_dd;
    assign rx_word     = {rx_shift[DATA_WIDTH-2:0], mosi_d};
    assign frame_start = (state == ST_IDLE) && !cs_n_d;
    assign word_done   = (state == ST_SHIFT) && !cs_n_d && sck_rise && (bit_cnt == LAST);
    assign shift_load  = frame_start || word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_d    <= 1'b0;
            sck_dd   <= 1'b0;
            cs_n_d   <= 1'b1;
            mosi_d   <= 1'b0;
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            sck_d  <= sck_s;
            sck_dd <= sck_d;
            cs_n_d <= cs_n_s;
            mosi_d <= mosi_s;
            rx_rdy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cs_n_d) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Deselect has priority over a coincident sck rise; the partial word is dropped.
                    if (cs_n_d) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_word;
                        if (bit_cnt == LAST) begin
                            rx_data <= rx_word;
                            rx_rdy  <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Transmit path: a shifter load empties tx_hold; a coincident tx_load bypasses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            tx_hold  <= '0;
        end else if (shift_load) begin
            tx_shift <= tx_load ? tx_data : tx_hold;
            tx_hold  <= '0;
        end else begin
            if (tx_load) begin
                tx_hold <= tx_data;
            end
            if ((state == ST_SHIFT) && !cs_n_d && sck_fall && (bit_cnt != '0)) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_TX_UNDERRUN_EN
    logic hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (shift_load) begin
                hold_full <= 1'b0;
            end else if (tx_load) begin
                hold_full <= 1'b1;
            end
            // A new frame clears the flag and then evaluates its own first load.
            if (frame_start) begin
                tx_underrun <= !hold_full && !tx_load;
            end else if (word_done && !hold_full && !tx_load) begin
                tx_underrun <= 1'b1;
            end
        end
    end
`endif

    assign miso = (state == ST_SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;
    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed scenarios plus random frames against a word-level model.
module tb_spi_slave_if;

    localparam int W    = 8;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sck = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         tx_load = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso, rx_rdy, busy;
    logic [W-1:0] rx_data;
`ifdef SPI_TX_UNDERRUN_EN
    logic         tx_underrun;
`endif

    spi_slave_if #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .sck(sck),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso),
        .rx_data(rx_data),
        .rx_rdy(rx_rdy),
        .tx_data(tx_data),
        .tx_load(tx_load),
`ifdef SPI_TX_UNDERRUN_EN
        .tx_underrun(tx_underrun),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // rx_rdy monitor, sampled 1 time unit after each rising edge.
    int           rdy_cnt = 0;
    int           rdy_cyc = 0;
    logic [W-1:0] rdy_data = '0;
    always @(posedge clk) begin
        #1;
        if (rx_rdy === 1'b1) begin
            rdy_cnt  = rdy_cnt + 1;
            rdy_cyc  = cyc;
            rdy_data = rx_data;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: one holding register that empties on every shifter load.
    logic [W-1:0] m_hold  = '0;
    bit           m_full  = 1'b0;
    bit           m_under = 1'b0;
    logic [W-1:0] exp_tx  = '0;
    int           rise_cyc = 0;

    function automatic logic [W-1:0] model_load(input bit byp, input logic [W-1:0] bv);
        logic [W-1:0] w;
        if (byp) begin
            w = bv;
        end else begin
            w = m_full ? m_hold : '0;
            if (!m_full) m_under = 1'b1;
        end
        m_hold = '0;
        m_full = 1'b0;
        return w;
    endfunction

    task automatic core_load(input logic [W-1:0] v);
        tx_load = 1'b1;
        tx_data = v;
        @(negedge clk);
        tx_load = 1'b0;
        m_hold  = v;
        m_full  = 1'b1;
    endtask

    task automatic start_frame();
        m_under = 1'b0;
        exp_tx  = model_load(1'b0, '0);
        cs_n    = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
`ifdef SPI_TX_UNDERRUN_EN
        check("underrun_frame_start", 32'(tx_underrun), 32'(m_under));
`endif
    endtask

    task automatic end_frame();
        sck = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("miso_idle", 32'(miso), 32'd0);
    endtask

    // Drives nbits of mo MSB first at clk/8; optional mid-word tx_load and word-end bypass load.
    task automatic send_word(input logic [W-1:0] mo, input int nbits,
                             input bit mid_ld, input logic [W-1:0] mid_v,
                             input bit byp, input logic [W-1:0] byp_v,
                             output logic [W-1:0] mi);
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            sck  = 1'b0;
            mosi = mo[W-1-k];
            if (k == 3 && mid_ld) begin
                tx_load = 1'b1;
                tx_data = mid_v;
                @(negedge clk);
                tx_load = 1'b0;
                m_hold  = mid_v;
                m_full  = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            mi[W-1-k] = miso;
            sck = 1'b1;
            if (k == W - 1) rise_cyc = cyc;
            if (k == W - 1 && byp) begin
                repeat (SYNC + 1) @(negedge clk);
                tx_load = 1'b1;
                tx_data = byp_v;
                @(negedge clk);
                tx_load = 1'b0;
                repeat (3 - SYNC) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic do_byte(input logic [W-1:0] mo, input bit mid_ld, input logic [W-1:0] mid_v,
                           input bit byp, input logic [W-1:0] byp_v);
        int           n0;
        logic [W-1:0] got;
        n0 = rdy_cnt;
        send_word(mo, W, mid_ld, mid_v, byp, byp_v, got);
        check("rx_rdy_pulses", 32'(rdy_cnt), 32'(n0 + 1));
        check("rx_data_strobe", 32'(rdy_data), 32'(mo));
        check("rx_data_port", 32'(rx_data), 32'(mo));
        check("rx_latency", 32'(rdy_cyc - rise_cyc), 32'(SYNC + 2));
        check("miso_word", 32'(got), 32'(exp_tx));
        exp_tx = model_load(byp, byp_v);
`ifdef SPI_TX_UNDERRUN_EN
        check("underrun_word_end", 32'(tx_underrun), 32'(m_under));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n0;
        logic [W-1:0] dummy;

        // Reset with pins idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_rdy", 32'(rx_rdy), 32'd0);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
`ifdef SPI_TX_UNDERRUN_EN
        check("reset_underrun", 32'(tx_underrun), 32'd0);
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // RX 0xA5 with TX 0x3C preloaded; second word must transmit 0x00 (underrun at byte-1 end).
        core_load(8'h3C);
        start_frame();
        do_byte(8'hA5, 1'b0, '0, 1'b0, '0);
        do_byte(8'h5A, 1'b0, '0, 1'b0, '0);
        end_frame();

        // Bypass: tx_load coincident with the byte-1 completion load.
        core_load(8'h11);
        start_frame();
        do_byte(8'hC3, 1'b0, '0, 1'b1, 8'h81);
        do_byte(8'h24, 1'b0, '0, 1'b0, '0);
        end_frame();

        // Abort after 5 bits, then a clean 0x0F frame.
        start_frame();
        n0 = rdy_cnt;
        send_word(8'hF0, 5, 1'b0, '0, 1'b0, '0, dummy);
        end_frame();
        check("abort_no_rx_rdy", 32'(rdy_cnt), 32'(n0));
        start_frame();
        do_byte(8'h0F, 1'b0, '0, 1'b0, '0);
        end_frame();

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            int nw;
            if ($urandom_range(0, 1) == 1) core_load(W'($urandom));
            start_frame();
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                do_byte(W'($urandom), $urandom_range(0, 2) == 0, W'($urandom),
                        $urandom_range(0, 3) == 0, W'($urandom));
            end
            end_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
